// File: rtl/thresh_scan_ctrl.sv
// -----------------------------------------------------------------------------
// thresh_scan_ctrl
//
// Raster-scan sequencer for the binary threshold stage. A start request in IDLE
// latches the threshold and walks a SIZE x SIZE pixel buffer in row-major order.
// Each read returns one cycle later; the pixel is compared against the latched
// threshold and written as 8'd255 / 8'd0 into a 2-entry output FIFO. The
// consumer side is a valid/ready stream carrying frame markers.
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_pix and
// the sof/eol/eof flags stay stable. out_valid never depends on out_ready.
//
// Ports
//   clk          single clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   start        begin a frame scan (sampled in IDLE only)
//   thresh_val   unsigned threshold, latched when start is accepted
//   mem_row      buffer read row address (holds unless a read is issued)
//   mem_col      buffer read column address
//   mem_rd_en    read strobe; mem_rd_data is valid exactly one cycle later
//   mem_rd_data  pixel read data (unsigned, PIX_W bits)
//   out_pix      thresholded pixel, 8'd255 or 8'd0
//   out_valid    out_pix and flags valid
//   out_ready    consumer accepts when out_valid & out_ready
//   out_sof      beat is pixel (0,0)
//   out_eol      beat is at column SIZE-1
//   out_eof      beat is pixel (SIZE-1,SIZE-1)
//   busy         controller not in IDLE
//   done         one-cycle pulse once the whole frame has been delivered
//   state_dbg    current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module thresh_scan_ctrl #(
   parameter int SIZE   = 10,
   parameter int PIX_W  = 9,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        thresh_val,
   output logic [ADDR_W-1:0] mem_row,
   output logic [ADDR_W-1:0] mem_col,
   output logic              mem_rd_en,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic [7:0]        out_pix,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

   state_t              state;
   state_t              state_nx;

   logic [7:0]          thr_q;       // threshold captured at start
   logic [ADDR_W-1:0]   row;         // address of the next read to issue
   logic [ADDR_W-1:0]   col;
   logic                rd_q;        // a read is in flight, data arrives this cycle
   logic [2:0]          flg_q;       // {sof,eol,eof} of the read in flight

   logic [10:0]         fifo_q [2];  // {pix[7:0], sof, eol, eof}
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          cnt;
   logic [1:0]          cnt_nx;

   logic                pop;
   logic                push;
   logic                issue;
   logic                at_last;
   logic [2:0]          occ;
   logic                pix_hi;
   logic [2:0]          addr_flags;
   logic [10:0]         head;

   // ---------------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------------
   assign pop  = out_valid & out_ready;
   assign push = rd_q;

   // Slots that will still be claimed after this cycle's pop: FIFO entries plus
   // the read in flight. A new read is only issued when that leaves room, so
   // returned data always finds a free FIFO slot. With out_ready held high the
   // steady state is one entry + one in flight + one pop, which still admits a
   // read every cycle.
   assign occ    = {1'b0, cnt} + {2'b00, rd_q} - {2'b00, pop};
   assign issue  = (state == S_SCAN) && (occ < 3'd2);
   assign cnt_nx = cnt + {1'b0, push} - {1'b0, pop};

   assign at_last = (row == LAST) && (col == LAST);

   // Frame markers belong to the address being read this cycle.
   assign addr_flags = {(row == '0) && (col == '0),
                        (col == LAST),
                        at_last};

   // Unsigned, strictly-greater comparison against the zero-extended threshold.
   assign pix_hi = (mem_rd_data > {{(PIX_W-8){1'b0}}, thr_q});

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_SCAN;
            end
         end
         S_SCAN: begin
            if (issue && at_last) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // No reads are issued here, so nothing will be in flight next cycle;
            // the frame is delivered once the FIFO will be empty after this edge.
            if (cnt_nx == 2'd0) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Threshold latch and read address generator
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         thr_q <= 8'd0;
         row   <= '0;
         col   <= '0;
      end else if ((state == S_IDLE) && start) begin
         thr_q <= thresh_val;
         row   <= '0;
         col   <= '0;
      end else if (issue && !at_last) begin
         // The address parks on the final pixel once it has been read.
         if (col == LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // In-flight tracking: mirrors the one-cycle read latency of the buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q  <= 1'b0;
         flg_q <= 3'b000;
      end else begin
         rd_q <= issue;
         if (issue) begin
            flg_q <= addr_flags;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // 2-entry output FIFO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_q[0] <= 11'd0;
         fifo_q[1] <= 11'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         cnt       <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= {(pix_hi ? 8'd255 : 8'd0), flg_q};
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign head = fifo_q[rd_ptr];

   // Payload is forced to zero whenever no beat is offered, so stale FIFO
   // contents never show on the stream.
   assign out_valid = (cnt != 2'd0);
   assign out_pix   = out_valid ? head[10:3] : 8'd0;
   assign out_sof   = out_valid & head[2];
   assign out_eol   = out_valid & head[1];
   assign out_eof   = out_valid & head[0];

   assign mem_row   = row;
   assign mem_col   = col;
   assign mem_rd_en = issue;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_thresh_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_thresh_scan_ctrl
//
// Bench for thresh_scan_ctrl. A behavioural image buffer answers reads one
// cycle later; the expected beat stream of each frame is computed from the
// image and the threshold and held in exp_q, which the stream monitor drains.
// -----------------------------------------------------------------------------
module tb_thresh_scan_ctrl;

   localparam int SIZE   = 10;
   localparam int PIX_W  = 9;
   localparam int ADDR_W = 8;
   localparam int NPIX   = SIZE * SIZE;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              start;
   logic [7:0]        thresh_val;
   logic [ADDR_W-1:0] mem_row;
   logic [ADDR_W-1:0] mem_col;
   logic              mem_rd_en;
   logic [PIX_W-1:0]  mem_rd_data;
   logic [7:0]        out_pix;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eol;
   logic              out_eof;
   logic              busy;
   logic              done;
   logic [1:0]        state_dbg;

   thresh_scan_ctrl #(.SIZE(SIZE), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .thresh_val  (thresh_val),
      .mem_row     (mem_row),
      .mem_col     (mem_col),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_data (mem_rd_data),
      .out_pix     (out_pix),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sof     (out_sof),
      .out_eol     (out_eol),
      .out_eof     (out_eof),
      .busy        (busy),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Image buffer model (synchronous read)
   // ---------------------------------------------------------------------------
   logic [PIX_W-1:0] img [SIZE][SIZE];

   always @(posedge clk) begin
      if (mem_rd_en && (int'(mem_row) < SIZE) && (int'(mem_col) < SIZE)) begin
         mem_rd_data <= img[int'(mem_row)][int'(mem_col)];
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [10:0] exp_q[$];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int beats_acc;
   int rd_issued;
   int done_cnt;
   int last_beat_cyc;
   bit mon_en;
   bit stall_prev;
   logic [11:0] held;
   bit hold_rdy;
   int rdy_mode;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: thresholded raster stream of the current image
   // ---------------------------------------------------------------------------
   task automatic build_expected(input logic [7:0] thr);
      exp_q.delete();
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            logic [7:0] p;
            logic s, e, f;
            p = (int'(img[r][c]) > int'(thr)) ? 8'd255 : 8'd0;
            s = (r == 0) && (c == 0);
            e = (c == SIZE - 1);
            f = (r == SIZE - 1) && (c == SIZE - 1);
            exp_q.push_back({p, s, e, f});
         end
      end
   endtask

   task automatic load_ramp();
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            img[r][c] = PIX_W'(r * 10 + c);
   endtask

   task automatic load_rand();
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            img[r][c] = PIX_W'($urandom_range(0, 511));
   endtask

   // ---------------------------------------------------------------------------
   // Consumer ready driver
   // ---------------------------------------------------------------------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (hold_rdy) out_ready = 1'b0;
         else begin
            case (rdy_mode)
               1:       out_ready = ~out_ready;
               2:       out_ready = 1'($urandom_range(0, 1));
               default: out_ready = 1'b1;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stream monitor
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            if (mem_rd_en) rd_issued++;
            if (stall_prev)
               check_eq("stall_hold", 32'({out_valid, out_pix, out_sof, out_eol, out_eof}), 32'(held));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq("beat_overrun", 32'(exp_q.size()), 32'd1);
               end else begin
                  logic [10:0] item;
                  item = exp_q.pop_front();
                  check_eq($sformatf("beat%0d", beats_acc),
                           32'({out_pix, out_sof, out_eol, out_eof}), 32'(item));
               end
               beats_acc++;
               if (beats_acc == NPIX) last_beat_cyc = cyc;
            end
            check_eq("outstanding_le2", 32'((rd_issued - beats_acc) <= 2), 32'd1);
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_pix, out_sof, out_eol, out_eof};
            if (done) done_cnt++;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic check_idle(input string tag);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_pix"},   32'(out_pix),   32'd0);
      check_eq({tag, "_flags"}, 32'({out_sof, out_eol, out_eof}), 32'd0);
      check_eq({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      check_eq({tag, "_addr"},  32'({mem_row, mem_col}), 32'd0);
      check_eq({tag, "_busy"},  32'(busy), 32'd0);
      check_eq({tag, "_done"},  32'(done), 32'd0);
   endtask

   // Pulses start with thr, checks first-read and first-beat latency. With
   // hold set the consumer is stalled from before the start.
   task automatic do_start(input logic [7:0] thr, input bit hold);
      build_expected(thr);
      beats_acc  = 0;
      rd_issued  = 0;
      done_cnt   = 0;
      stall_prev = 0;
      mon_en     = 1;
      if (hold) begin
         hold_rdy = 1;
         @(posedge clk);
      end
      @(posedge clk); #1;
      start = 1'b1;
      thresh_val = thr;
      @(posedge clk); #1;
      start = 1'b0;
      thresh_val = 8'($urandom_range(0, 255));
      check_eq("lat_rd_en", 32'(mem_rd_en), 32'd1);
      check_eq("lat_addr0", 32'({mem_row, mem_col}), 32'd0);
      check_eq("lat_busy", 32'(busy), 32'd1);
      check_eq("lat_valid_e0", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_valid_e1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("lat_valid_e2", 32'(out_valid), 32'd1);
   endtask

   task automatic finish_frame();
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("done_seen", 32'(done), 32'd1);
      check_eq("busy_in_done", 32'(busy), 32'd1);
      check_eq("beats_total", 32'(beats_acc), 32'(NPIX));
      check_eq("exp_left", 32'(exp_q.size()), 32'd0);
      check_eq("done_delay", 32'(cyc - last_beat_cyc), 32'd1);
      @(posedge clk); #1;
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("done_fall", 32'(done), 32'd0);
      check_eq("busy_fall", 32'(busy), 32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      thresh_val = 8'd0;
      mon_en = 0;
      hold_rdy = 0;
      rdy_mode = 0;
      last_beat_cyc = 0;
      load_ramp();
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("post_reset");

      // T1: ramp image, threshold 50, consumer always ready
      load_ramp();
      rdy_mode = 0;
      do_start(8'd50, 0);
      finish_frame();

      // T2: same frame with ready toggling every cycle
      rdy_mode = 1;
      do_start(8'd50, 0);
      finish_frame();

      // T3: boundary pixel values around the thresholds
      load_rand();
      img[0][0] = 9'd255; img[0][1] = 9'd256; img[0][2] = 9'd511; img[0][3] = 9'd254;
      rdy_mode = 2;
      do_start(8'd255, 0);
      finish_frame();
      load_rand();
      img[0][0] = 9'd0; img[4][4] = 9'd0; img[9][9] = 9'd1;
      do_start(8'd0, 0);
      finish_frame();

      // T4: start pulsed mid-frame with a different threshold is ignored
      load_ramp();
      rdy_mode = 0;
      do_start(8'd50, 0);
      repeat (30) @(posedge clk);
      #1;
      start = 1'b1;
      thresh_val = 8'd10;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("mid_start_busy", 32'(busy), 32'd1);
      finish_frame();

      // T5: reset in the middle of a frame, then a clean full frame
      load_rand();
      do_start(8'($urandom_range(0, 255)), 0);
      begin
         int n;
         n = 0;
         while (beats_acc < 37 && n < 500) begin
            @(posedge clk); #1;
            n++;
         end
         check_eq("reach_beat37", 32'(beats_acc >= 37), 32'd1);
      end
      mon_en = 0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle("midrst");
      repeat (4) begin
         @(posedge clk); #1;
         check_eq("midrst_no_done", 32'(done), 32'd0);
         check_eq("midrst_no_valid", 32'(out_valid), 32'd0);
      end
      do_start(8'd128, 0);
      finish_frame();

      // T6: consumer stalled for ~20 cycles after start
      rdy_mode = 0;
      do_start(8'd100, 1);
      repeat (17) @(posedge clk);
      #1;
      check_eq("stall_reads", 32'(rd_issued), 32'd2);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      hold_rdy = 0;
      finish_frame();

      // Randomized frames with random consumer back-pressure
      rdy_mode = 2;
      repeat (2) begin
         load_rand();
         do_start(8'($urandom_range(0, 255)), 0);
         finish_frame();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
